// File: rtl/load_store_unit_if.sv
// Request, data-memory bus and writeback signals of the load/store unit.
// master = surrounding pipeline/memory, slave = the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned Xlen    = 32,
    parameter int unsigned RegSelW = 5
);
    logic               mem_valid;
    logic               mem_read;
    logic               mem_write;
    logic [Xlen-1:0]    mem_addr;
    logic [Xlen-1:0]    mem_data;
    logic [2:0]         mem_funct3;
    logic [RegSelW-1:0] mem_rd_addr;
    logic               busy;

    logic               dmem_req;
    logic               dmem_we;
    logic [Xlen-1:0]    dmem_addr;
    logic [Xlen-1:0]    dmem_wdata;
    logic [3:0]         dmem_be;
    logic               dmem_ack;
    logic [Xlen-1:0]    dmem_rdata;

    logic               reg_dv;
    logic [RegSelW-1:0] reg_addr;
    logic [Xlen-1:0]    reg_data;
    logic               misalign;
    logic               timeout;

    modport master (
        output mem_valid, mem_read, mem_write, mem_addr, mem_data, mem_funct3, mem_rd_addr,
        output dmem_ack, dmem_rdata,
        input  busy, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  reg_dv, reg_addr, reg_data, misalign, timeout
    );

    modport slave (
        input  mem_valid, mem_read, mem_write, mem_addr, mem_data, mem_funct3, mem_rd_addr,
        input  dmem_ack, dmem_rdata,
        output busy, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output reg_dv, reg_addr, reg_data, misalign, timeout
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store responder: one data-memory access per accepted request,
// byte-lane store formatting and aligned, extended load writeback.
module load_store_unit #(
    parameter int unsigned Xlen    = 32,
    parameter int unsigned RegSelW = 5,
    parameter int unsigned Timeout = 255
) (
    input logic               clk_i,
    input logic               rst_ni,
    load_store_unit_if.slave  bus_io
);
    localparam int unsigned CntW = (Timeout < 2) ? 1 : $clog2(Timeout);
    localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic               busy_q, req_q, we_q;
    logic [Xlen-1:0]    addr_q, wdata_q;
    logic [3:0]         be_q;
    logic [2:0]         funct3_q;
    logic [1:0]         off_q;
    logic [RegSelW-1:0] rd_q;
    logic               reg_dv_q, misalign_q, timeout_q;
    logic [RegSelW-1:0] reg_addr_q;
    logic [Xlen-1:0]    reg_data_q;

    logic            req_ok, f3_ok, align_ok;
    logic [1:0]      a_lo;
    logic [3:0]      be_d;
    logic [Xlen-1:0] wdata_d, rsh, load_data;

    always_comb begin
        a_lo = bus_io.mem_addr[1:0];
        case (bus_io.mem_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = bus_io.mem_read;
            default:                f3_ok = 1'b0;
        endcase
        case (bus_io.mem_funct3[1:0])
            2'b01:   align_ok = ~a_lo[0];
            2'b10:   align_ok = (a_lo == 2'b00);
            default: align_ok = 1'b1;
        endcase
        req_ok = (bus_io.mem_read ^ bus_io.mem_write) & f3_ok & align_ok;

        case (bus_io.mem_funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << a_lo;
                wdata_d = {4{bus_io.mem_data[7:0]}};
            end
            2'b01: begin
                be_d    = a_lo[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{bus_io.mem_data[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = bus_io.mem_data;
            end
        endcase
        if (!bus_io.mem_write) begin
            be_d    = 4'b1111;
            wdata_d = '0;
        end

        // Halfwords are 2-byte aligned, so the byte-lane shift also selects the half lane.
        rsh = bus_io.dmem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{rsh[7]}}, rsh[7:0]};
            3'b100:  load_data = {24'd0, rsh[7:0]};
            3'b001:  load_data = {{16{rsh[15]}}, rsh[15:0]};
            3'b101:  load_data = {16'd0, rsh[15:0]};
            default: load_data = bus_io.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            funct3_q   <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            reg_dv_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            reg_dv_q   <= 1'b0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus_io.mem_valid) begin
                        if (req_ok) begin
                            state_q  <= StReq;
                            busy_q   <= 1'b1;
                            req_q    <= 1'b1;
                            we_q     <= bus_io.mem_write;
                            addr_q   <= {bus_io.mem_addr[Xlen-1:2], 2'b00};
                            wdata_q  <= wdata_d;
                            be_q     <= be_d;
                            funct3_q <= bus_io.mem_funct3;
                            off_q    <= a_lo;
                            rd_q     <= bus_io.mem_rd_addr;
                            cnt_q    <= '0;
                        end else begin
                            misalign_q <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (bus_io.dmem_ack || (cnt_q == CntLast)) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        be_q    <= '0;
                    end
                    if (bus_io.dmem_ack) begin
                        if (we_q) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StResp;
                            if (rd_q != '0) begin
                                reg_dv_q   <= 1'b1;
                                reg_addr_q <= rd_q;
                                reg_data_q <= load_data;
                            end
                        end
                    end else if (cnt_q == CntLast) begin
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.busy       = busy_q;
    assign bus_io.dmem_req   = req_q;
    assign bus_io.dmem_we    = we_q;
    assign bus_io.dmem_addr  = addr_q;
    assign bus_io.dmem_wdata = wdata_q;
    assign bus_io.dmem_be    = be_q;
    assign bus_io.reg_dv     = reg_dv_q;
    assign bus_io.reg_addr   = reg_addr_q;
    assign bus_io.reg_data   = reg_data_q;
    assign bus_io.misalign   = misalign_q;
    assign bus_io.timeout    = timeout_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts every
// output cycle by cycle; a single negedge process compares the DUT against it.
module tb_load_store_unit;
    localparam int unsigned TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_store_unit_if #(.Xlen(32), .RegSelW(5)) bus ();

    load_store_unit #(
        .Xlen    (32),
        .RegSelW (5),
        .Timeout (TIMEOUT)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    typedef struct packed {
        logic        busy, req, we;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        dv;
        logic [4:0]  raddr;
        logic [31:0] rdata;
        logic        mis, to;
    } exp_t;

    exp_t ex;
    int   n_err = 0;
    int   n_chk = 0;
    bit   cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(bus.busy), 32'(ex.busy));
            chk("dmem_req", 32'(bus.dmem_req), 32'(ex.req));
            chk("reg_dv", 32'(bus.reg_dv), 32'(ex.dv));
            chk("reg_addr", 32'(bus.reg_addr), 32'(ex.raddr));
            chk("reg_data", bus.reg_data, ex.rdata);
            chk("misalign", 32'(bus.misalign), 32'(ex.mis));
            chk("timeout", 32'(bus.timeout), 32'(ex.to));
            if (ex.req) begin
                chk("dmem_we", 32'(bus.dmem_we), 32'(ex.we));
                chk("dmem_addr", bus.dmem_addr, ex.addr);
                chk("dmem_be", 32'(bus.dmem_be), 32'(ex.be));
                if (ex.we) chk("dmem_wdata", bus.dmem_wdata, ex.wdata);
            end
        end
    end

    function automatic bit model_ok(input logic r, input logic w, input logic [2:0] f3,
                                    input logic [31:0] a);
        bit f_ok;
        int size;
        if (r == w) return 1'b0;
        if (w) f_ok = (f3 <= 3'd2);
        else   f_ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!f_ok) return 1'b0;
        size = 1 << f3[1:0];
        return (int'(a[1:0]) % size) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic w, input logic [2:0] f3,
                                            input logic [31:0] a);
        int nbytes;
        if (!w) return 4'hF;
        nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'd0:    return 32'(d[7:0]) * 32'h0101_0101;
            2'd1:    return 32'(d[15:0]) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0]    w;
        byte signed     sb;
        shortint signed sh;
        if (f3[1:0] == 2'd1) w = rdata >> (16 * int'(a[1]));
        else                 w = rdata >> (8 * int'(a[1:0]));
        case (f3)
            3'd0: begin
                sb = w[7:0];
                return 32'(int'(sb));
            end
            3'd4: return {24'd0, w[7:0]};
            3'd1: begin
                sh = w[15:0];
                return 32'(int'(sh));
            end
            3'd5: return {16'd0, w[15:0]};
            default: return rdata;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.mem_valid   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_funct3  = 3'd0;
        bus.mem_addr    = 32'd0;
        bus.mem_data    = 32'd0;
        bus.mem_rd_addr = 5'd0;
    endtask

    // ack_dly: REQ cycles before ack (0 = first REQ cycle), negative = never ack.
    task automatic run_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                          input int ack_dly, input logic [31:0] rdata,
                          input bit has_lit, input logic [31:0] lit, input bit junk);
        int n;
        bus.mem_valid   = 1'b1;
        bus.mem_read    = rd_en;
        bus.mem_write   = wr_en;
        bus.mem_funct3  = f3;
        bus.mem_addr    = a;
        bus.mem_data    = d;
        bus.mem_rd_addr = rd;
        tick();
        clear_req();
        ex = '0;
        if (!model_ok(rd_en, wr_en, f3, a)) begin
            ex.mis = 1'b1;
            tick();
            ex = '0;
            return;
        end
        ex.busy  = 1'b1;
        ex.req   = 1'b1;
        ex.we    = wr_en;
        ex.addr  = {a[31:2], 2'b00};
        ex.be    = model_be(wr_en, f3, a);
        ex.wdata = model_wdata(f3, d);
        if (has_lit && wr_en) begin
            #2;
            chk("lit_wdata", bus.dmem_wdata, lit);
        end
        if (junk) begin
            bus.mem_valid   = 1'b1;
            bus.mem_write   = 1'b1;
            bus.mem_funct3  = 3'd2;
            bus.mem_addr    = 32'h300;
            bus.mem_data    = 32'h1234_5678;
        end
        n = 0;
        forever begin
            if (ack_dly >= 0 && n == ack_dly) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = rdata;
                tick();
                clear_req();
                bus.dmem_ack = 1'b0;
                break;
            end
            if (n == int'(TIMEOUT) - 1) begin
                tick();
                clear_req();
                ex    = '0;
                ex.to = 1'b1;
                tick();
                ex = '0;
                return;
            end
            n++;
            tick();
            clear_req();
        end
        ex = '0;
        if (!wr_en) begin
            ex.busy = 1'b1;
            if (rd != 5'd0) begin
                ex.dv    = 1'b1;
                ex.raddr = rd;
                ex.rdata = model_load(f3, a, rdata);
            end
            if (has_lit) begin
                #2;
                chk("lit_rdata", bus.reg_data, lit);
            end
            tick();
            ex = '0;
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        clear_req();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'd0;
        ex             = '0;
        repeat (3) tick();
        cmp_en = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Stores and loads with hand-computed lane results
        run_op(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 5'd0, 2, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        tick();
        run_op(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 5'd5, 0, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80, 1'b0);
        run_op(1'b1, 1'b0, 3'd4, 32'h103, 32'd0, 5'd5, 0, 32'h80FF_0000, 1'b1, 32'h0000_0080, 1'b0);
        run_op(1'b0, 1'b1, 3'd1, 32'h102, 32'h0000_ABCD, 5'd0, 0, 32'd0, 1'b1, 32'hABCD_ABCD, 1'b0);
        run_op(1'b1, 1'b0, 3'd1, 32'h102, 32'd0, 5'd7, 1, 32'h8001_1234, 1'b1, 32'hFFFF_8001, 1'b0);
        run_op(1'b1, 1'b0, 3'd5, 32'h102, 32'd0, 5'd7, 0, 32'h8001_1234, 1'b1, 32'h0000_8001, 1'b0);
        run_op(1'b0, 1'b1, 3'd0, 32'h101, 32'h0000_005A, 5'd0, 0, 32'd0, 1'b1, 32'h5A5A_5A5A, 1'b0);
        run_op(1'b1, 1'b0, 3'd0, 32'h101, 32'd0, 5'd2, 0, 32'h0000_7F00, 1'b1, 32'h0000_007F, 1'b0);
        run_op(1'b1, 1'b0, 3'd2, 32'h104, 32'd0, 5'd0, 0, 32'hCAFE_F00D, 1'b0, 32'd0, 1'b0);

        // Illegal and misaligned requests, then a legal one
        run_op(1'b1, 1'b0, 3'd2, 32'h101, 32'd0, 5'd3, 0, 32'd0, 1'b0, 32'd0, 1'b0);
        run_op(1'b1, 1'b0, 3'd3, 32'h100, 32'd0, 5'd3, 0, 32'd0, 1'b0, 32'd0, 1'b0);
        run_op(1'b1, 1'b1, 3'd2, 32'h100, 32'd0, 5'd3, 0, 32'd0, 1'b0, 32'd0, 1'b0);
        run_op(1'b0, 1'b0, 3'd2, 32'h100, 32'd0, 5'd3, 0, 32'd0, 1'b0, 32'd0, 1'b0);
        run_op(1'b0, 1'b1, 3'd4, 32'h100, 32'd0, 5'd0, 0, 32'd0, 1'b0, 32'd0, 1'b0);
        run_op(1'b0, 1'b1, 3'd1, 32'h103, 32'd0, 5'd0, 0, 32'd0, 1'b0, 32'd0, 1'b0);
        run_op(1'b1, 1'b0, 3'd2, 32'h108, 32'd0, 5'd3, 0, 32'h1122_3344, 1'b1, 32'h1122_3344, 1'b0);

        // Ack on the last allowed REQ cycle, then a full timeout and a stray ack
        run_op(1'b1, 1'b0, 3'd2, 32'h10C, 32'd0, 5'd8, int'(TIMEOUT) - 1, 32'h0BAD_C0DE,
               1'b1, 32'h0BAD_C0DE, 1'b0);
        run_op(1'b1, 1'b0, 3'd2, 32'h110, 32'd0, 5'd9, -1, 32'd0, 1'b0, 32'd0, 1'b0);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h5555_AAAA;
        tick();
        bus.dmem_ack = 1'b0;
        repeat (2) tick();

        // Asynchronous reset in the middle of a bus access
        bus.mem_valid   = 1'b1;
        bus.mem_read    = 1'b1;
        bus.mem_funct3  = 3'd2;
        bus.mem_addr    = 32'h180;
        bus.mem_rd_addr = 5'd4;
        tick();
        clear_req();
        ex      = '0;
        ex.busy = 1'b1;
        ex.req  = 1'b1;
        ex.addr = 32'h180;
        ex.be   = 4'hF;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_be", 32'(bus.dmem_be), 32'd0);
        ex = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_op(1'b1, 1'b0, 3'd2, 32'h200, 32'd0, 5'd6, 1, 32'h0102_0304, 1'b1, 32'h0102_0304, 1'b1);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
